calc_cmd_sequencer: RTL and testbench
=====================================

Name: calc_cmd_sequencer

Overview:
- Sits between the keypad/command source and the calculator datapath (cmd/status interface).
- Buffers incoming 4-bit command codes in a small FIFO.
- Issues each code to the calculator exactly once, using the calculator's status handshake: 00 = error, 01 = busy, 10 = ready.
- Drives NOP between issues, detects datapath error, and provides a clear path that resets the calculator.

Parameters:
DEPTH, 8, FIFO entries (power of two, >=2)
NOP_CMD, 4'hD, code driven on calc_cmd whenever no command is being issued
TIMEOUT, 1024, cycles allowed in ISSUE before a forced error (used only with the optional feature)

Ports:
clock  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
key_valid  input  1  command code valid
key_code  input  4  command code (0-9 digits, A-C ops, E equals, F backspace)
key_ready  output  1  sequencer can accept key_code this cycle
clear  input  1  one-cycle request: flush and reset the calculator
calc_status  input  2  calculator status (00 error, 01 busy, 10 ready)
calc_cmd  output  4  command to calculator (registered)
calc_reset  output  1  reset to calculator (registered)
seq_busy  output  1  FIFO non-empty or a command is in flight
seq_error  output  1  sequencer in ERROR
fifo_level  output  $clog2(DEPTH+1)  current FIFO occupancy

Behaviour:
- Reset values:
  - state = IDLE, FIFO empty, fifo_level = 0.
  - calc_cmd = NOP_CMD, calc_reset = 1, key_ready = 0, seq_busy = 0, seq_error = 0.
- calc_reset is 1 for the reset cycle plus the first cycle after reset deasserts, then 0 unless clear is asserted.
- Push: occurs when key_valid && key_ready.
  - key_ready = !full && state != ERROR && !clear, computed from registered state.
  - Full means level == DEPTH. A pop in the same cycle does not make room for a push when full.
  - Push and pop in the same cycle with 0 < level < DEPTH leaves level unchanged.
- Pointers wrap modulo DEPTH.
- States:
  - IDLE:
    - calc_cmd = NOP_CMD.
    - If FIFO non-empty and calc_status == 10: pop head into cur_cmd and go to ISSUE; calc_cmd = cur_cmd from the next cycle.
    - If calc_status == 00: go to ERROR.
  - ISSUE:
    - calc_cmd = cur_cmd.
    - Hold while calc_status == 10.
    - calc_status == 01: go to WAIT_READY and set calc_cmd = NOP_CMD on the transition.
    - calc_status == 00: go to ERROR.
  - WAIT_READY:
    - calc_cmd = NOP_CMD.
    - calc_status == 10: go to IDLE. The next pop is allowed in the following cycle, giving a minimum spacing of 2 cycles of NOP.
    - calc_status == 00: go to ERROR.
  - ERROR:
    - seq_error = 1, calc_cmd = NOP_CMD.
    - FIFO flushed on entry; pushes blocked.
    - Remains in ERROR until clear or reset.
- clear (any state, highest priority after reset):
  - FIFO flushed, cur_cmd discarded, calc_reset = 1 for exactly one cycle (next cycle), seq_error = 0, go to WAIT_READY.
  - A push offered in the clear cycle is dropped (key_ready = 0).
- Latency: key accepted at cycle t with an idle, ready calculator gives calc_cmd = code at t+2.
- seq_busy = (level != 0) || state in {ISSUE, WAIT_READY}.
- Long busy periods (e.g. iterative multiply) are unbounded in WAIT_READY. No timeout applies there.

Optional Feature:
- Macro CALC_SEQ_TIMEOUT_EN.
- When defined: a counter ($clog2(TIMEOUT+1) bits) clears on entry to ISSUE and increments each ISSUE cycle. Reaching TIMEOUT with calc_status still 10 forces ERROR (datapath ignored the command).
- When undefined: no counter; ISSUE waits indefinitely.

Decomposition:
- Shared package calc_pkg holds:
  - status constants ST_ERR = 2'b00, ST_BUSY = 2'b01, ST_READY = 2'b10;
  - command constants CMD_ADD = 4'hA, CMD_SUB = 4'hB, CMD_MUL = 4'hC, CMD_EQ = 4'hE, CMD_BKSP = 4'hF;
  - the sequencer state enum typedef.
- One sub-module: calc_cmd_fifo (synchronous FIFO with push/pop/level/flush, parameter DEPTH).

Test Plan:
1. Reset, then status=10 and push 3: calc_reset high for 1 post-reset cycle. calc_cmd = 3 two cycles after acceptance, held until status = 01, then NOP (4'hD).
2. Push 1,2,A,4,E back-to-back; the bench model returns 01 for 3 cycles then 10 after each command. calc_cmd shows 1,2,A,4,E in order, each separated by NOP, with no code repeated.
3. Fill with 8 keys while status stays 01: key_ready drops at level 8, the 9th key is not accepted, and level stays 8. On status 10 the first pop occurs and key_ready rises the next cycle.
4. Status = 00 while in WAIT_READY with 3 keys queued: ERROR next cycle, seq_error = 1, fifo_level = 0, key_ready = 0. Then clear: calc_reset = 1 for one cycle, seq_error = 0, state WAIT_READY until status = 10.
5. Multiply: status held at 01 for 40 cycles after C issued. The sequencer stays in WAIT_READY with NOP and no error.
6. With CALC_SEQ_TIMEOUT_EN and TIMEOUT = 16: status stuck at 10 after issue gives seq_error = 1 exactly 16 cycles after entering ISSUE. Without the macro, there is still no error after 100 cycles.

Source files
------------

// File: rtl/calc_pkg.sv
// calc_pkg: shared constants and types for the calculator command path.
//   - calculator status codes (calc_status encoding)
//   - named command codes for the operator keys
//   - sequencer state enumeration
package calc_pkg;

  localparam int unsigned CMD_W  = 4;
  localparam int unsigned STAT_W = 2;

  localparam logic [STAT_W-1:0] ST_ERR   = 2'b00;
  localparam logic [STAT_W-1:0] ST_BUSY  = 2'b01;
  localparam logic [STAT_W-1:0] ST_READY = 2'b10;

  localparam logic [CMD_W-1:0] CMD_ADD  = 4'hA;
  localparam logic [CMD_W-1:0] CMD_SUB  = 4'hB;
  localparam logic [CMD_W-1:0] CMD_MUL  = 4'hC;
  localparam logic [CMD_W-1:0] CMD_EQ   = 4'hE;
  localparam logic [CMD_W-1:0] CMD_BKSP = 4'hF;

  typedef enum logic [1:0] {
    SEQ_IDLE       = 2'd0,
    SEQ_ISSUE      = 2'd1,
    SEQ_WAIT_READY = 2'd2,
    SEQ_ERROR      = 2'd3
  } seq_state_e;

endpackage

// File: rtl/calc_cmd_fifo.sv
// calc_cmd_fifo: synchronous command FIFO with flush.
// Ports:
//   clock, reset      rising-edge clock, synchronous active-high reset
//   push_i, data_i    write request and command code (ignored when full)
//   pop_i             read request (ignored when empty)
//   flush_i           discard all entries (wins over push/pop)
//   head_o            oldest entry, valid when !empty_o
//   level_o           occupancy 0..DEPTH
//   full_o, empty_o   occupancy flags
// DEPTH must be a power of two >= 2 so pointers wrap naturally.
module calc_cmd_fifo
  import calc_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic [CMD_W-1:0]           data_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output logic [CMD_W-1:0]           head_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = $clog2(DEPTH+1);

  logic [CMD_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [LVL_W-1:0] level_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (level_q == LVL_W'(DEPTH));
  assign empty_o = (level_q == '0);
  // A pop never frees a slot for a same-cycle push when full.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];
  assign level_o = level_q;

  // Storage, pointers and occupancy
  always_ff @(posedge clock) begin
    if (reset || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/calc_cmd_sequencer.sv
// calc_cmd_sequencer: buffers keypad command codes and issues each one to the
// calculator datapath exactly once using its status handshake
// (00 error, 01 busy, 10 ready). NOP_CMD is driven between issues.
// Ports:
//   clock, reset            rising-edge clock, synchronous active-high reset
//   key_valid, key_code     incoming command; accepted when key_ready
//   key_ready               room in FIFO, not in ERROR, no clear this cycle
//   clear                   flush everything and pulse calc_reset
//   calc_status             calculator status
//   calc_cmd, calc_reset    registered command / reset to the calculator
//   seq_busy                FIFO non-empty or a command in flight
//   seq_error               sequencer is in ERROR
//   fifo_level              FIFO occupancy
// Optional: define CALC_SEQ_TIMEOUT_EN to force ERROR when the calculator
// stays ready for TIMEOUT cycles after a command is issued.
module calc_cmd_sequencer
  import calc_pkg::*;
#(
  parameter int unsigned      DEPTH   = 8,
  parameter logic [CMD_W-1:0] NOP_CMD = 4'hD,
  parameter int unsigned      TIMEOUT = 1024
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       key_valid,
  input  logic [3:0]                 key_code,
  output logic                       key_ready,
  input  logic                       clear,
  input  logic [1:0]                 calc_status,
  output logic [3:0]                 calc_cmd,
  output logic                       calc_reset,
  output logic                       seq_busy,
  output logic                       seq_error,
  output logic [$clog2(DEPTH+1)-1:0] fifo_level
);

  seq_state_e       state_q;
  logic [CMD_W-1:0] cur_cmd_q;
  logic [CMD_W-1:0] calc_cmd_q;
  logic             calc_reset_q;
  logic             seq_error_q;

  logic             fifo_full;
  logic             fifo_empty;
  logic [CMD_W-1:0] fifo_head;
  logic             push;
  logic             pop;
  logic             flush;
  logic             tmo_hit;
  logic             go_error;

`ifdef CALC_SEQ_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT+1);

  logic [TMO_W-1:0] tmo_cnt_q;

  // Held at zero outside ISSUE, so it restarts on every ISSUE entry
  always_ff @(posedge clock) begin
    if (reset || clear || state_q != SEQ_ISSUE) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
    end
  end

  // Last allowed ISSUE cycle with the datapath still ignoring the command
  assign tmo_hit = (state_q == SEQ_ISSUE) && (calc_status == ST_READY) &&
                   (tmo_cnt_q == TMO_W'(TIMEOUT - 1));
`else
  logic unused_timeout;

  assign unused_timeout = (TIMEOUT == 0);
  assign tmo_hit        = 1'b0;
`endif

  assign go_error  = (state_q != SEQ_ERROR) && ((calc_status == ST_ERR) || tmo_hit);
  assign key_ready = !reset && !fifo_full && (state_q != SEQ_ERROR) && !clear;
  assign push      = key_valid && key_ready;
  assign pop       = (state_q == SEQ_IDLE) && !fifo_empty &&
                     (calc_status == ST_READY) && !clear && !reset;
  // Queue is emptied on clear, on the edge into ERROR, and while in ERROR
  assign flush     = clear || go_error || (state_q == SEQ_ERROR);

  calc_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (push),
    .data_i  (key_code),
    .pop_i   (pop),
    .flush_i (flush),
    .head_o  (fifo_head),
    .level_o (fifo_level),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Sequencer state and registered calculator-facing outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= SEQ_IDLE;
      cur_cmd_q    <= NOP_CMD;
      calc_cmd_q   <= NOP_CMD;
      calc_reset_q <= 1'b1;
      seq_error_q  <= 1'b0;
    end else if (clear) begin
      state_q      <= SEQ_WAIT_READY;
      cur_cmd_q    <= NOP_CMD;
      calc_cmd_q   <= NOP_CMD;
      calc_reset_q <= 1'b1;
      seq_error_q  <= 1'b0;
    end else begin
      calc_reset_q <= 1'b0;
      if (go_error) begin
        state_q     <= SEQ_ERROR;
        calc_cmd_q  <= NOP_CMD;
        seq_error_q <= 1'b1;
      end else begin
        case (state_q)
          SEQ_IDLE: begin
            calc_cmd_q <= NOP_CMD;
            if (pop) begin
              state_q    <= SEQ_ISSUE;
              cur_cmd_q  <= fifo_head;
              calc_cmd_q <= fifo_head;
            end
          end
          SEQ_ISSUE: begin
            calc_cmd_q <= cur_cmd_q;
            if (calc_status == ST_BUSY) begin
              state_q    <= SEQ_WAIT_READY;
              calc_cmd_q <= NOP_CMD;
            end
          end
          SEQ_WAIT_READY: begin
            calc_cmd_q <= NOP_CMD;
            if (calc_status == ST_READY) begin
              state_q <= SEQ_IDLE;
            end
          end
          default: begin
            calc_cmd_q <= NOP_CMD;
          end
        endcase
      end
    end
  end

  assign calc_cmd   = calc_cmd_q;
  assign calc_reset = calc_reset_q;
  assign seq_error  = seq_error_q;
  assign seq_busy   = (fifo_level != '0) || (state_q == SEQ_ISSUE) ||
                      (state_q == SEQ_WAIT_READY);

endmodule

// File: tb/tb_calc_cmd_sequencer.sv
// Scoreboard bench for calc_cmd_sequencer: accepted keys are queued as
// expected issues; a negedge monitor checks every new command the DUT drives.
module tb_calc_cmd_sequencer;
  import calc_pkg::*;

  localparam logic [3:0] NOP = 4'hD;

  logic       clock;
  logic       reset;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_ready;
  logic       clear;
  logic [1:0] calc_status;
  logic [3:0] calc_cmd;
  logic       calc_reset;
  logic       seq_busy;
  logic       seq_error;
  logic [3:0] fifo_level;

  logic       auto_mode;
  logic [1:0] forced_status;
  logic [1:0] model_status;
  int         busy_left;

  logic [3:0] exp_q[$];
  int         n_cmp;
  int         n_err;
  int         issue_cnt;
  logic [3:0] prev_cmd;

  calc_cmd_sequencer #(
    .DEPTH   (8),
    .NOP_CMD (NOP),
    .TIMEOUT (16)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .key_ready   (key_ready),
    .clear       (clear),
    .calc_status (calc_status),
    .calc_cmd    (calc_cmd),
    .calc_reset  (calc_reset),
    .seq_busy    (seq_busy),
    .seq_error   (seq_error),
    .fifo_level  (fifo_level)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign calc_status = auto_mode ? model_status : forced_status;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Offer one key for one cycle; queue it as an expected issue when accepted
  task automatic send_key(input logic [3:0] code);
    key_valid = 1'b1;
    key_code  = code;
    #0;
    if (key_ready) exp_q.push_back(code);
    tick();
    key_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || seq_busy) && n < budget) begin
      tick();
      n++;
    end
    check(name, 32'(n < budget), 32'd1);
  endtask

  // Calculator model: busy for 3 cycles after each newly issued command
  initial begin
    model_status = ST_READY;
    busy_left    = 0;
    forever begin
      @(posedge clock);
      #1;
      if (!auto_mode) begin
        busy_left    = 0;
        model_status = ST_READY;
      end else if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) model_status = ST_READY;
      end else if (calc_cmd != NOP && model_status == ST_READY) begin
        model_status = ST_BUSY;
        busy_left    = 3;
      end
    end
  end

  // Monitor: every change to a non-NOP command is one issue
  initial begin
    prev_cmd  = NOP;
    issue_cnt = 0;
    forever begin
      @(negedge clock);
      if (!reset && calc_cmd != NOP && calc_cmd != prev_cmd) begin
        issue_cnt++;
        check("issue_gap", 32'(prev_cmd), 32'(NOP));
        if (exp_q.size() == 0) begin
          check("unexpected_issue", 32'(calc_cmd), 32'(NOP));
        end else begin
          check("issue_code", 32'(calc_cmd), 32'(exp_q.pop_front()));
        end
      end
      if (!reset) prev_cmd = calc_cmd;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int bad;
    int n;
    n_cmp         = 0;
    n_err         = 0;
    reset         = 1'b1;
    key_valid     = 1'b0;
    key_code      = 4'h0;
    clear         = 1'b0;
    auto_mode     = 1'b0;
    forced_status = ST_READY;

    // Reset values
    tick();
    check("rst_calc_cmd", 32'(calc_cmd), 32'(NOP));
    check("rst_calc_reset", 32'(calc_reset), 32'd1);
    check("rst_key_ready", 32'(key_ready), 32'd0);
    check("rst_seq_busy", 32'(seq_busy), 32'd0);
    check("rst_seq_error", 32'(seq_error), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    tick();
    reset = 1'b0;
    #0;
    check("post_rst_calc_reset", 32'(calc_reset), 32'd1);

    // Test 1: single key, latency 2, hold until busy
    check("t1_key_ready", 32'(key_ready), 32'd1);
    send_key(4'h3);
    check("t1_calc_reset_low", 32'(calc_reset), 32'd0);
    check("t1_cmd_t1", 32'(calc_cmd), 32'(NOP));
    check("t1_level", 32'(fifo_level), 32'd1);
    tick();
    check("t1_cmd_t2", 32'(calc_cmd), 32'h3);
    check("t1_busy", 32'(seq_busy), 32'd1);
    tick();
    tick();
    check("t1_hold", 32'(calc_cmd), 32'h3);
    forced_status = ST_BUSY;
    tick();
    check("t1_nop_after_busy", 32'(calc_cmd), 32'(NOP));
    forced_status = ST_READY;
    tick();
    tick();
    check("t1_idle", 32'(seq_busy), 32'd0);

    // Test 2: back-to-back keys against the calculator model
    auto_mode = 1'b1;
    base      = issue_cnt;
    send_key(4'h1);
    send_key(4'h2);
    send_key(CMD_ADD);
    send_key(4'h4);
    send_key(CMD_EQ);
    wait_drain("t2_drain", 200);
    check("t2_issue_count", 32'(issue_cnt - base), 32'd5);

    // Test 3: fill while busy, full blocks the ninth key
    auto_mode     = 1'b0;
    forced_status = ST_BUSY;
    tick();
    for (int i = 0; i < 8; i++) send_key(4'(i + 5));
    check("t3_level_full", 32'(fifo_level), 32'd8);
    check("t3_ready_full", 32'(key_ready), 32'd0);
    send_key(4'h3);
    check("t3_level_stays", 32'(fifo_level), 32'd8);
    forced_status = ST_READY;
    #0;
    check("t3_ready_before_pop", 32'(key_ready), 32'd0);
    tick();
    check("t3_level_after_pop", 32'(fifo_level), 32'd7);
    check("t3_ready_after_pop", 32'(key_ready), 32'd1);
    auto_mode = 1'b1;
    wait_drain("t3_drain", 400);

    // Test 4: error in WAIT_READY with keys queued, then clear
    auto_mode     = 1'b0;
    forced_status = ST_READY;
    tick();
    send_key(4'h9);
    tick();
    key_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      key_code = 4'(i);
      tick();
    end
    key_valid     = 1'b0;
    forced_status = ST_BUSY;
    tick();
    check("t4_level_queued", 32'(fifo_level), 32'd3);
    forced_status = ST_ERR;
    tick();
    check("t4_seq_error", 32'(seq_error), 32'd1);
    check("t4_level_flushed", 32'(fifo_level), 32'd0);
    check("t4_key_ready", 32'(key_ready), 32'd0);
    check("t4_err_cmd", 32'(calc_cmd), 32'(NOP));
    forced_status = ST_READY;
    tick();
    check("t4_err_sticky", 32'(seq_error), 32'd1);
    clear         = 1'b1;
    key_valid     = 1'b1;
    key_code      = 4'h5;
    forced_status = ST_BUSY;
    #0;
    check("t4_ready_in_clear", 32'(key_ready), 32'd0);
    tick();
    clear     = 1'b0;
    key_valid = 1'b0;
    check("t4_calc_reset", 32'(calc_reset), 32'd1);
    check("t4_err_cleared", 32'(seq_error), 32'd0);
    check("t4_level_after_clear", 32'(fifo_level), 32'd0);
    check("t4_wait_busy", 32'(seq_busy), 32'd1);
    tick();
    check("t4_calc_reset_pulse", 32'(calc_reset), 32'd0);
    check("t4_still_wait", 32'(seq_busy), 32'd1);
    forced_status = ST_READY;
    tick();
    check("t4_back_idle", 32'(seq_busy), 32'd0);

    // Test 5: long multiply, no timeout in WAIT_READY
    send_key(CMD_MUL);
    tick();
    check("t5_issue_mul", 32'(calc_cmd), 32'(CMD_MUL));
    forced_status = ST_BUSY;
    tick();
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      if (calc_cmd != NOP || seq_error || !seq_busy) bad++;
      tick();
    end
    check("t5_long_busy", 32'(bad), 32'd0);
    forced_status = ST_READY;
    tick();
    tick();

    // Test 6: calculator ignores the issued command
    send_key(4'h6);
    tick();
    check("t6_issue", 32'(calc_cmd), 32'h6);
`ifdef CALC_SEQ_TIMEOUT_EN
    n = 0;
    while (!seq_error && n < 200) begin
      tick();
      n++;
    end
    check("t6_timeout_cycles", 32'(n), 32'd16);
`else
    for (int i = 0; i < 100; i++) tick();
    check("t6_no_timeout", 32'(seq_error), 32'd0);
    check("t6_still_issuing", 32'(calc_cmd), 32'h6);
`endif

    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
